// File: rtl/out_ser_pkg.sv
// Shared types and sizing helpers for the pad output serializer.
// Optional pad parity output is enabled with `define OUT_SER_PARITY_EN.
package out_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int beats(input int word_w, input int pad_w);
        return word_w / pad_w;
    endfunction

    function automatic int cnt_w(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/pad_out_shreg.sv
// Loadable left-shift register stepping PAD_W bits per shift.
// The top PAD_W bits are always the next beat to go out.
module pad_out_shreg #(
    parameter int WORD_W = 16,
    parameter int PAD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [PAD_W-1:0]  msb_o
);

    logic [WORD_W-1:0] sh_q;

    // Load wins over shift so a new word can replace the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= data_i;
        end else if (shift_i) begin
            sh_q <= sh_q << PAD_W;
        end
    end

    assign msb_o = sh_q[WORD_W-1 -: PAD_W];

endmodule

// File: rtl/pad_out_serializer.sv
// Word-to-pad serializer: MSB-first PAD_W-bit beats with word-start marker.
// Define OUT_SER_PARITY_EN to add the registered pad_parity output.
module pad_out_serializer
    import out_ser_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int PAD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              pad_stall,
    output logic [PAD_W-1:0]  pad_data,
    output logic              pad_valid,
    output logic              pad_first,
    output logic              busy
`ifdef OUT_SER_PARITY_EN
    ,
    output logic              pad_parity
`endif
);

    localparam int BEATS = beats(WORD_W, PAD_W);
    localparam int CW    = cnt_w(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if (WORD_W % PAD_W != 0) begin : g_bad_param
        $error("pad_out_serializer: WORD_W must be a multiple of PAD_W");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PAD_W-1:0]  pad_data_q, pad_data_d;
    logic              pad_valid_q, pad_valid_d;
    logic              pad_first_q, pad_first_d;
    logic [PAD_W-1:0]  beat;
    logic              load, shift;
`ifdef OUT_SER_PARITY_EN
    logic              par_q, par_d;
`endif

    pad_out_shreg #(
        .WORD_W (WORD_W),
        .PAD_W  (PAD_W)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (in_data),
        .msb_o   (beat)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pad_data_d  = pad_data_q;
        pad_valid_d = pad_valid_q;
        pad_first_d = pad_first_q;
        in_ready    = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
`ifdef OUT_SER_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                in_ready    = 1'b1;
                pad_valid_d = 1'b0;
                pad_first_d = 1'b0;
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!pad_stall) begin
                    shift       = 1'b1;
                    pad_data_d  = beat;
                    pad_valid_d = 1'b1;
                    pad_first_d = (cnt_q == '0);
`ifdef OUT_SER_PARITY_EN
                    par_d       = ^beat;
`endif
                    // Accepting on the last beat keeps back-to-back words gapless.
                    if (cnt_q == LAST) begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pad_data_q  <= '0;
            pad_valid_q <= 1'b0;
            pad_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pad_data_q  <= pad_data_d;
            pad_valid_q <= pad_valid_d;
            pad_first_q <= pad_first_d;
        end
    end

`ifdef OUT_SER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign pad_parity = par_q;
`endif

    assign pad_data  = pad_data_q;
    assign pad_valid = pad_valid_q;
    assign pad_first = pad_first_q;
    assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_pad_out_serializer.sv
// Self-checking bench for pad_out_serializer (WORD_W=16, PAD_W=4).
// Beat-queue reference model plus directed literal checks.
module tb_pad_out_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pad_stall = 1'b0;
    logic [3:0]  pad_data;
    logic        pad_valid;
    logic        pad_first;
    logic        busy;
`ifdef OUT_SER_PARITY_EN
    logic        pad_parity;
`endif

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    pad_out_serializer #(
        .WORD_W (16),
        .PAD_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pad_stall (pad_stall),
        .pad_data  (pad_data),
        .pad_valid (pad_valid),
        .pad_first (pad_first),
        .busy      (busy)
`ifdef OUT_SER_PARITY_EN
        ,
        .pad_parity(pad_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: queue of beats not yet shown ({first, data}).
    logic [4:0] mq[$];
    logic [3:0] e_data;
    logic       e_valid;
    logic       e_first;

    function automatic bit m_ready();
        return (mq.size() == 0) || (mq.size() == 1 && !pad_stall);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        if (!rst_n) begin
            mq.delete();
            e_data  = '0;
            e_valid = 1'b0;
            e_first = 1'b0;
        end else begin
            acc = in_valid && m_ready();
            if (mq.size() != 0) begin
                if (!pad_stall) begin
                    {e_first, e_data} = mq.pop_front();
                    e_valid = 1'b1;
                end
            end else begin
                e_valid = 1'b0;
                e_first = 1'b0;
            end
            if (acc) begin
                for (int k = 0; k < 4; k++)
                    mq.push_back({k == 0, in_data[15-4*k -: 4]});
            end
        end
    end

    // Trace of shown beats for literal checks.
    logic [4:0] seen[$];
    int         seen_cyc[$];
    logic       seen_par[$];

    always @(negedge clk) begin
        cyc++;
        chk("in_ready", in_ready, m_ready());
        chk("busy", busy, mq.size() != 0);
        chk("pad_valid", pad_valid, e_valid);
        chk("pad_first", pad_first, e_first);
        chk("pad_data", pad_data, e_data);
`ifdef OUT_SER_PARITY_EN
        if (e_valid) chk("pad_parity", pad_parity, ^e_data);
        else if (!rst_n) chk("pad_parity_rst", pad_parity, 0);
`endif
        if (rst_n && pad_valid) begin
            seen.push_back({pad_first, pad_data});
            seen_cyc.push_back(cyc);
`ifdef OUT_SER_PARITY_EN
            seen_par.push_back(pad_parity);
`endif
        end
    end

    task automatic clr();
        seen.delete();
        seen_cyc.delete();
        seen_par.delete();
    endtask

    task automatic send(input logic [15:0] w, input bit keep);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_seen(input string nm, input logic [4:0] exp[]);
        chk({nm, "_len"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            chk(nm, seen[i], exp[i]);
    endtask

    initial begin
        #1;
        chk("rst_valid", pad_valid, 0);
        chk("rst_data", pad_data, 0);
        chk("rst_first", pad_first, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        #11 rst_n = 1'b1;
        idle(2);

        // Single word
        clr();
        send(16'hA5C3, 0);
        idle(6);
        chk_seen("single", '{5'h1A, 5'h05, 5'h0C, 5'h03});

        // Back-to-back words with in_valid held
        clr();
        send(16'h1234, 1);
        send(16'hFEDC, 0);
        idle(6);
        chk_seen("b2b", '{5'h11, 5'h02, 5'h03, 5'h04,
                          5'h1F, 5'h0E, 5'h0D, 5'h0C});
        if (seen_cyc.size() == 8)
            chk("b2b_span", seen_cyc[7] - seen_cyc[0], 7);

        // Pad stall while beat 5 is shown
        clr();
        send(16'hA5C3, 0);
        idle(2);
        chk("stall_pre", pad_data, 4'h5);
        pad_stall = 1'b1;
        repeat (3) begin
            chk("stall_rdy", in_ready, 0);
            idle(1);
            chk("stall_hold", {pad_valid, pad_data}, 5'h15);
        end
        pad_stall = 1'b0;
        idle(6);
        chk_seen("stall", '{5'h1A, 5'h05, 5'h05, 5'h05, 5'h05,
                            5'h0C, 5'h03});

        // Stall in IDLE is ignored
        pad_stall = 1'b1;
        #1;
        chk("idle_stall_rdy", in_ready, 1);
        pad_stall = 1'b0;

        // Reset during beat 2 of 0xBEEF
        clr();
        send(16'hBEEF, 0);
        idle(3);
        chk("pre_rst_data", pad_data, 4'hE);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", pad_valid, 0);
        chk("mid_rst_data", pad_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_first", pad_first, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        clr();
        send(16'h0F0F, 0);
        idle(6);
        chk_seen("after_rst", '{5'h10, 5'h0F, 5'h00, 5'h0F});

        // Core stall after a word
        send(16'h5A5A, 0);
        idle(5);
        repeat (5) begin
            chk("core_idle_v", pad_valid, 0);
            chk("core_idle_r", in_ready, 1);
            chk("core_idle_b", busy, 0);
            idle(1);
        end

`ifdef OUT_SER_PARITY_EN
        clr();
        send(16'h7100, 0);
        idle(6);
        chk_seen("par_beats", '{5'h17, 5'h01, 5'h00, 5'h00});
        chk("par_len", seen_par.size(), 4);
        if (seen_par.size() == 4)
            chk("par_seq", {seen_par[0], seen_par[1], seen_par[2],
                            seen_par[3]}, 4'b1100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
